// File: rtl/cpu_types_pkg.sv
// Shared types for the direct-mapped instruction cache.
// Struct widths below describe the default 16-set layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDXW  = 4;
  localparam int ICACHE_TAGW  = 32 - ICACHE_IDXW - 2;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  function automatic word_t word_align(word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the icache.
// slave is the cache view, master the fetch/memory view.
interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  inval;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_stats.sv
// Hit/miss counters for the icache, built only with ICACHE_STATS_EN.
// Both wrap modulo 2^32 and clear only on RST.
module icache_stats
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  hit_evt,
  input  logic  miss_evt,
  output word_t hit_count,
  output word_t miss_count
);

  word_t hit_q, hit_d;
  word_t miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q + word_t'(hit_evt);
    miss_d = miss_q + word_t'(miss_evt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-line instruction cache with IDLE/FETCH fill FSM.
// Define ICACHE_STATS_EN to add hit_count/miss_count ports.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS
) (
  input  logic  CLK,
  input  logic  RST,
  icache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;

  logic [NSETS-1:0] valid_q;
  logic [TAGW-1:0]  tag_q [NSETS];
  word_t            data_q [NSETS];

  logic [IDXW-1:0] req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            hit, fill_done, fill_we;

  assign req_idx  = bus.imemaddr[IDXW+1:2];
  assign req_tag  = bus.imemaddr[31:IDXW+2];
  assign fill_idx = miss_addr_q[IDXW+1:2];
  assign fill_tag = miss_addr_q[31:IDXW+2];

  assign hit = (state_q == IDLE) && bus.imemREN &&
               valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit) begin
          state_d     = FETCH;
          miss_addr_d = word_align(bus.imemaddr);
        end
      end
      FETCH: begin
        if (!bus.iwait) begin
          state_d   = IDLE;
          fill_done = 1'b1;
        end
      end
    endcase
  end

  // invalidation in the completing cycle drops the fill
  assign fill_we = fill_done && !bus.inval;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (bus.inval)
        valid_q <= '0;
      else if (fill_we)
        valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : '0;
  assign bus.iREN     = (state_q == FETCH);
  assign bus.iaddr    = (state_q == FETCH) ? miss_addr_q : '0;

`ifdef ICACHE_STATS_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = hit;
  assign miss_evt = (state_q == IDLE) && (state_d == FETCH);

  icache_stats u_stats (
    .CLK        (CLK),
    .RST        (RST),
    .hit_evt    (hit_evt),
    .miss_evt   (miss_evt),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule
